// File: rtl/pifo_pkg.sv
// Shared ordering constants and the priority comparison used by the PIFO set.
package pifo_pkg;

  localparam int ORD_MAX_FIRST = 0;
  localparam int ORD_MIN_FIRST = 1;
  localparam int PRIO_MAX_W    = 32;

  // Strict precedence only; equal priorities never beat each other, which keeps ties FIFO.
  function automatic logic prio_beats(input logic [PRIO_MAX_W-1:0] a,
                                      input logic [PRIO_MAX_W-1:0] b,
                                      input logic                  min_first);
    return min_first ? (a < b) : (a > b);
  endfunction

endpackage

// File: rtl/pifo_insert_pos.sv
// Insertion index for a sorted list: the number of valid entries the new entry does not beat.
module pifo_insert_pos
  import pifo_pkg::*;
#(
  parameter int NUM_ELEMENTS = 16,
  parameter int POS_W        = $clog2(NUM_ELEMENTS + 1)
)(
  input  logic [NUM_ELEMENTS-1:0] beats,
  input  logic [NUM_ELEMENTS-1:0] valid,
  output logic [POS_W-1:0]        pos
);

  always_comb begin
    pos = '0;
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      pos = pos + POS_W'(valid[i] & ~beats[i]);
    end
  end

endmodule

// File: rtl/pifo_set_ord.sv
// Sorted PIFO set with push, pop and head-reinsert per cycle plus per-flow occupancy.
// Optional statistics counters are enabled by defining PIFO_SET_ORD_STATS_EN.
module pifo_set_ord
  import pifo_pkg::*;
#(
  parameter int NUM_ELEMENTS = 16,
  parameter int PRIO_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_FLOWS    = 2**DATA_WIDTH,
  parameter int MIN_FIRST    = 0
)(
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                i__push_valid,
  input  logic [PRIO_WIDTH-1:0]               i__push_priority,
  input  logic [DATA_WIDTH-1:0]               i__push_flow_id,
  output logic                                o__push_ready,
  output logic                                o__push_flow_empty,
  input  logic                                i__pop,
  output logic                                o__pop_valid,
  output logic [PRIO_WIDTH-1:0]               o__pop_priority,
  output logic [DATA_WIDTH-1:0]               o__pop_flow_id,
  input  logic                                i__reinsert_valid,
  input  logic [PRIO_WIDTH-1:0]               i__reinsert_priority,
  output logic                                o__reinsert_err,
  output logic [$clog2(NUM_ELEMENTS+1)-1:0]   o__count,
  input  logic                                i__clear_all
`ifdef PIFO_SET_ORD_STATS_EN
  ,
  output logic [31:0]                         o__stat_push_cnt,
  output logic [31:0]                         o__stat_pop_cnt,
  output logic [31:0]                         o__stat_drop_cnt
`endif
);

  localparam int CW = $clog2(NUM_ELEMENTS + 1);
  localparam int IW = CW + 1;
  localparam logic [IW-1:0] NO_SLOT = IW'(NUM_ELEMENTS + 1);
  localparam logic MIN_MODE = (MIN_FIRST == ORD_MIN_FIRST);

  typedef struct packed {
    logic [PRIO_WIDTH-1:0] prio;
    logic [DATA_WIDTH-1:0] flow;
  } entry_t;

  entry_t ent_reg  [NUM_ELEMENTS];
  entry_t ent_next [NUM_ELEMENTS];
  entry_t rem      [NUM_ELEMENTS];
  entry_t sh1      [NUM_ELEMENTS];
  entry_t sh2      [NUM_ELEMENTS];
  logic [CW-1:0] fcnt_reg  [NUM_FLOWS];
  logic [CW-1:0] fcnt_next [NUM_FLOWS];
  logic [CW-1:0] count_reg, count_next, rem_count;
  logic [CW-1:0] push_pos, rein_pos;
  logic [NUM_ELEMENTS-1:0] valid_mask, push_beats, rein_beats;
  logic [IW-1:0] a_idx, b_idx;
  entry_t a_ent, b_ent, push_ent, rein_ent;
  logic push_acc, pop_acc, rein_acc, push_over_rein;
  logic reinsert_err_reg;

  assign o__push_ready      = (count_reg < CW'(NUM_ELEMENTS)) & ~reset;
  assign o__pop_valid       = (count_reg != '0) & ~reset;
  assign o__pop_priority    = ent_reg[0].prio;
  assign o__pop_flow_id     = ent_reg[0].flow;
  assign o__count           = count_reg;
  assign o__reinsert_err    = reinsert_err_reg;
  assign o__push_flow_empty = (fcnt_reg[i__push_flow_id] == '0);

  assign push_acc   = i__push_valid & o__push_ready;
  assign pop_acc    = i__pop & o__pop_valid;
  assign rein_acc   = i__reinsert_valid & pop_acc;
  assign rem_count  = count_reg - CW'(pop_acc);
  assign count_next = count_reg + CW'(push_acc) - CW'(pop_acc) + CW'(rein_acc);

  assign push_ent = '{prio: i__push_priority, flow: i__push_flow_id};
  assign rein_ent = '{prio: i__reinsert_priority, flow: ent_reg[0].flow};
  assign push_over_rein = prio_beats(PRIO_MAX_W'(i__push_priority),
                                     PRIO_MAX_W'(i__reinsert_priority), MIN_MODE);

  // rem is the list after an optional pop; sh1/sh2 are rem delayed by one and two slots.
  for (genvar gi = 0; gi < NUM_ELEMENTS; gi++) begin : g_slot
    if (gi < NUM_ELEMENTS - 1) begin : g_rem_mid
      assign rem[gi] = pop_acc ? ent_reg[gi+1] : ent_reg[gi];
    end else begin : g_rem_last
      assign rem[gi] = ent_reg[gi];
    end
    if (gi == 0) begin : g_sh0
      assign sh1[gi] = rem[0];
      assign sh2[gi] = rem[0];
    end else if (gi == 1) begin : g_sh1
      assign sh1[gi] = rem[0];
      assign sh2[gi] = rem[0];
    end else begin : g_shn
      assign sh1[gi] = rem[gi-1];
      assign sh2[gi] = rem[gi-2];
    end
    assign valid_mask[gi] = (CW'(gi) < rem_count);
    assign push_beats[gi] = prio_beats(PRIO_MAX_W'(i__push_priority),
                                       PRIO_MAX_W'(rem[gi].prio), MIN_MODE);
    assign rein_beats[gi] = prio_beats(PRIO_MAX_W'(i__reinsert_priority),
                                       PRIO_MAX_W'(rem[gi].prio), MIN_MODE);
    assign ent_next[gi] = (IW'(gi) >= IW'(count_next)) ? ent_reg[gi] :
                          (IW'(gi) <  a_idx)           ? rem[gi]     :
                          (IW'(gi) == a_idx)           ? a_ent       :
                          (IW'(gi) <  b_idx)           ? sh1[gi]     :
                          (IW'(gi) == b_idx)           ? b_ent       : sh2[gi];
  end

  pifo_insert_pos #(.NUM_ELEMENTS(NUM_ELEMENTS), .POS_W(CW)) u_push_pos (
    .beats (push_beats),
    .valid (valid_mask),
    .pos   (push_pos)
  );

  pifo_insert_pos #(.NUM_ELEMENTS(NUM_ELEMENTS), .POS_W(CW)) u_rein_pos (
    .beats (rein_beats),
    .valid (valid_mask),
    .pos   (rein_pos)
  );

  // With both inserts, the earlier one pushes the later one a slot further down.
  always_comb begin
    a_idx = NO_SLOT;
    b_idx = NO_SLOT;
    a_ent = push_ent;
    b_ent = rein_ent;
    if (push_acc && rein_acc) begin
      if (push_over_rein) begin
        a_idx = IW'(push_pos);
        b_idx = IW'(rein_pos) + IW'(1);
      end else begin
        a_idx = IW'(rein_pos);
        a_ent = rein_ent;
        b_idx = IW'(push_pos) + IW'(1);
        b_ent = push_ent;
      end
    end else if (push_acc) begin
      a_idx = IW'(push_pos);
    end else if (rein_acc) begin
      a_idx = IW'(rein_pos);
      a_ent = rein_ent;
    end
  end

  for (genvar gi = 0; gi < NUM_FLOWS; gi++) begin : g_flow
    logic head_hit;
    assign head_hit = (ent_reg[0].flow == DATA_WIDTH'(gi));
    assign fcnt_next[gi] = fcnt_reg[gi]
                         + CW'(push_acc && (i__push_flow_id == DATA_WIDTH'(gi)))
                         + CW'(rein_acc && head_hit)
                         - CW'(pop_acc && head_hit);
  end

  // Slot contents need no reset: anything at or beyond count is never compared.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      ent_reg[i] <= ent_next[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i__clear_all) begin
      count_reg        <= '0;
      reinsert_err_reg <= 1'b0;
      for (int f = 0; f < NUM_FLOWS; f++) begin
        fcnt_reg[f] <= '0;
      end
    end else begin
      count_reg        <= count_next;
      reinsert_err_reg <= i__reinsert_valid & ~pop_acc;
      for (int f = 0; f < NUM_FLOWS; f++) begin
        fcnt_reg[f] <= fcnt_next[f];
      end
    end
  end

`ifdef PIFO_SET_ORD_STATS_EN
  logic [31:0] stat_push_reg, stat_pop_reg, stat_drop_reg;

  always_ff @(posedge clk) begin
    if (reset || i__clear_all) begin
      stat_push_reg <= '0;
      stat_pop_reg  <= '0;
      stat_drop_reg <= '0;
    end else begin
      stat_push_reg <= stat_push_reg + 32'(push_acc);
      stat_pop_reg  <= stat_pop_reg + 32'(pop_acc);
      stat_drop_reg <= stat_drop_reg + 32'(i__push_valid & ~o__push_ready);
    end
  end

  assign o__stat_push_cnt = stat_push_reg;
  assign o__stat_pop_cnt  = stat_pop_reg;
  assign o__stat_drop_cnt = stat_drop_reg;
`endif

endmodule

// File: tb/tb_pifo_set_ord.sv
// Bench for pifo_set_ord: sorted-queue scoreboard plus table and hand-written corner sequences.
module tb_pifo_set_ord;
  import pifo_pkg::*;

  localparam int N = 16;

  typedef struct packed {
    logic [7:0] prio;
    logic [7:0] flow;
  } ent_t;

  typedef struct {
    bit pv;
    int pp;
    int pf;
    bit pop;
    int exp_cnt;
    int exp_head;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       push_valid = 1'b0, pop = 1'b0, rein_valid = 1'b0, clear_all = 1'b0;
  logic [7:0] push_priority = '0, push_flow_id = '0, rein_priority = '0;

  logic       mx_push_ready, mx_push_flow_empty, mx_pop_valid, mx_reinsert_err;
  logic [7:0] mx_pop_priority, mx_pop_flow_id;
  logic [4:0] mx_count;
  logic       mn_push_ready, mn_push_flow_empty, mn_pop_valid, mn_reinsert_err;
  logic [7:0] mn_pop_priority, mn_pop_flow_id;
  logic [4:0] mn_count;
`ifdef PIFO_SET_ORD_STATS_EN
  logic [31:0] mx_sp, mx_so, mx_sd, mn_sp, mn_so, mn_sd;
  int exp_sp = 0, exp_so = 0, exp_sd = 0;
`endif

  always #5 clk = ~clk;

  pifo_set_ord #(.MIN_FIRST(ORD_MAX_FIRST)) u_max (
    .clk(clk), .reset(reset),
    .i__push_valid(push_valid), .i__push_priority(push_priority), .i__push_flow_id(push_flow_id),
    .o__push_ready(mx_push_ready), .o__push_flow_empty(mx_push_flow_empty),
    .i__pop(pop), .o__pop_valid(mx_pop_valid), .o__pop_priority(mx_pop_priority),
    .o__pop_flow_id(mx_pop_flow_id), .i__reinsert_valid(rein_valid),
    .i__reinsert_priority(rein_priority), .o__reinsert_err(mx_reinsert_err),
    .o__count(mx_count), .i__clear_all(clear_all)
`ifdef PIFO_SET_ORD_STATS_EN
    , .o__stat_push_cnt(mx_sp), .o__stat_pop_cnt(mx_so), .o__stat_drop_cnt(mx_sd)
`endif
  );

  pifo_set_ord #(.MIN_FIRST(ORD_MIN_FIRST)) u_min (
    .clk(clk), .reset(reset),
    .i__push_valid(push_valid), .i__push_priority(push_priority), .i__push_flow_id(push_flow_id),
    .o__push_ready(mn_push_ready), .o__push_flow_empty(mn_push_flow_empty),
    .i__pop(pop), .o__pop_valid(mn_pop_valid), .o__pop_priority(mn_pop_priority),
    .o__pop_flow_id(mn_pop_flow_id), .i__reinsert_valid(rein_valid),
    .i__reinsert_priority(rein_priority), .o__reinsert_err(mn_reinsert_err),
    .o__count(mn_count), .i__clear_all(clear_all)
`ifdef PIFO_SET_ORD_STATS_EN
    , .o__stat_push_cnt(mn_sp), .o__stat_pop_cnt(mn_so), .o__stat_drop_cnt(mn_sd)
`endif
  );

  ent_t sb[$];
  int   fcnt[256];
  bit   exp_err = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference ordering: a new entry goes before the first entry it strictly beats (max-first).
  function automatic void sb_insert(input ent_t e);
    int pos = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (e.prio > sb[i].prio) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, e);
  endfunction

  function automatic void model_clear();
    sb.delete();
    for (int f = 0; f < 256; f++) fcnt[f] = 0;
    exp_err = 1'b0;
`ifdef PIFO_SET_ORD_STATS_EN
    exp_sp = 0; exp_so = 0; exp_sd = 0;
`endif
  endfunction

  // One clock: drive at negedge, check current state, update model at posedge, check err after.
  task automatic step(input bit pv, input int pp, input int pf, input bit p,
                      input bit rv, input int rp, input bit clr);
    bit   pa, oa, ra;
    ent_t head;
    push_valid = pv; push_priority = 8'(pp); push_flow_id = 8'(pf);
    pop = p; rein_valid = rv; rein_priority = 8'(rp); clear_all = clr;
    #1;
    chk("count", mx_count, sb.size());
    chk("min_count", mn_count, sb.size());
    chk("pop_valid", mx_pop_valid, sb.size() != 0);
    chk("push_ready", mx_push_ready, sb.size() < N);
    chk("flow_empty", mx_push_flow_empty, fcnt[pf] == 0);
    chk("min_flow_empty", mn_push_flow_empty, fcnt[pf] == 0);
    if (sb.size() != 0) begin
      chk("head_prio", mx_pop_priority, sb[0].prio);
      chk("head_flow", mx_pop_flow_id, sb[0].flow);
    end
    pa = pv && (sb.size() < N);
    oa = p && (sb.size() != 0);
    ra = rv && oa;
    @(posedge clk);
    if (clr) begin
      model_clear();
    end else begin
      exp_err = rv && !oa;
      if (oa) begin
        head = sb.pop_front();
        fcnt[head.flow]--;
        if (ra) begin
          sb_insert('{prio: 8'(rp), flow: head.flow});
          fcnt[head.flow]++;
        end
      end
      if (pa) begin
        sb_insert('{prio: 8'(pp), flow: 8'(pf)});
        fcnt[pf]++;
      end
`ifdef PIFO_SET_ORD_STATS_EN
      exp_sp += int'(pa); exp_so += int'(oa); exp_sd += int'(pv && !pa);
`endif
    end
    @(negedge clk);
    chk("reinsert_err", mx_reinsert_err, exp_err);
    chk("min_reinsert_err", mn_reinsert_err, exp_err);
    $display("step push=%0b/%0d/f%0d pop=%0b rein=%0b/%0d clr=%0b -> count=%0d",
             pv, pp, pf, p, rv, rp, clr, mx_count);
    push_valid = 1'b0; pop = 1'b0; rein_valid = 1'b0; clear_all = 1'b0;
  endtask

  task automatic do_reset();
    push_valid = 1'b0; pop = 1'b0; rein_valid = 1'b0; clear_all = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_push_ready", mx_push_ready, 0);
    chk("rst_pop_valid", mx_pop_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_count", mx_count, 0);
    chk("rst_err", mx_reinsert_err, 0);
    reset = 1'b0;
    model_clear();
  endtask

  vec_t tbl[8];
  int   exp_min[3];
  int   exp_flow[3];
  int   exp_sim[4];

  initial begin
    tbl[0] = '{1, 5, 1, 0, 1, 5};
    tbl[1] = '{1, 9, 2, 0, 2, 9};
    tbl[2] = '{1, 1, 3, 0, 3, 9};
    tbl[3] = '{1, 9, 7, 0, 4, 9};
    tbl[4] = '{0, 0, 0, 1, 3, 9};
    tbl[5] = '{0, 0, 0, 1, 2, 5};
    tbl[6] = '{0, 0, 0, 1, 1, 1};
    tbl[7] = '{0, 0, 0, 1, 0, 0};
    exp_min  = '{10, 20, 30};
    exp_flow = '{2, 3, 1};
    exp_sim  = '{25, 20, 15, 10};

    @(negedge clk);
    do_reset();

    // Max-first ordering with a tie on priority 9.
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].pv, tbl[i].pp, tbl[i].pf, tbl[i].pop, 0, 0, 0);
      chk("tbl_count", mx_count, tbl[i].exp_cnt);
      if (tbl[i].exp_cnt != 0) chk("tbl_head", mx_pop_priority, tbl[i].exp_head);
      if (i == 4) chk("tbl_tie_flow", mx_pop_flow_id, 7);
    end

    // Min-first ordering on the second instance.
    do_reset();
    step(1, 30, 1, 0, 0, 0, 0);
    step(1, 10, 2, 0, 0, 0, 0);
    step(1, 20, 3, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      chk("min_valid", mn_pop_valid, 1);
      chk("min_head", mn_pop_priority, exp_min[k]);
      step(0, 0, 0, 1, 0, 0, 0);
    end
    chk("min_empty", mn_pop_valid, 0);

    // Full: refused push, pop and reinsert of the head behind equal priorities.
    do_reset();
    for (int k = 0; k < 3; k++) step(1, 50, k + 1, 0, 0, 0, 0);
    for (int k = 0; k < 13; k++) step(1, 10 + k, 10 + k, 0, 0, 0, 0);
    chk("full_ready", mx_push_ready, 0);
    step(1, 50, 99, 1, 1, 50, 0);
    chk("full_count", mx_count, 16);
    for (int k = 0; k < 3; k++) begin
      chk("full_head_flow", mx_pop_flow_id, exp_flow[k]);
      step(0, 0, 0, 1, 0, 0, 0);
    end

    // Push, pop and reinsert together at count 3.
    do_reset();
    step(1, 40, 4, 0, 0, 0, 0);
    step(1, 20, 2, 0, 0, 0, 0);
    step(1, 10, 1, 0, 0, 0, 0);
    step(1, 25, 5, 1, 1, 15, 0);
    chk("sim_count", mx_count, 4);
    push_flow_id = 8'd4;
    #1;
    chk("sim_flow4_held", mx_push_flow_empty, 0);
    for (int k = 0; k < 4; k++) begin
      chk("sim_order", mx_pop_priority, exp_sim[k]);
      step(0, 0, 0, 1, 0, 0, 0);
    end

    // Reinsert without pop, including on an empty set.
    step(1, 60, 6, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 33, 0);
    chk("rerr_pulse", mx_reinsert_err, 1);
    chk("rerr_count", mx_count, 1);
    chk("rerr_head", mx_pop_priority, 60);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rerr_clears", mx_reinsert_err, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 7, 0);
    chk("rerr_empty", mx_reinsert_err, 1);

    // Clear together with a push at count 5.
    for (int k = 0; k < 5; k++) step(1, 3 * k, 20 + k, 0, 0, 0, 0);
    step(1, 77, 9, 0, 0, 0, 1);
    chk("clr_count", mx_count, 0);
    chk("clr_valid", mx_pop_valid, 0);
    for (int f = 0; f < 256; f++) begin
      push_flow_id = 8'(f);
      #1;
      chk("clr_flow_empty", mx_push_flow_empty, 1);
    end

    // Reset pulse mid-operation.
    for (int k = 0; k < 3; k++) step(1, 40 + k, 30 + k, 0, 0, 0, 0);
    chk("pre_rst_count", mx_count, 3);
    do_reset();
    step(0, 0, 30, 0, 0, 0, 0);

`ifdef PIFO_SET_ORD_STATS_EN
    for (int k = 0; k < 16; k++) step(1, k, k, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("stat_push", mx_sp, exp_sp);
    chk("stat_pop", mx_so, exp_so);
    chk("stat_drop", mx_sd, exp_sd);
    chk("min_stat_push", mn_sp, exp_sp);
    chk("min_stat_pop", mn_so, exp_so);
    chk("min_stat_drop", mn_sd, exp_sd);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pifo_set_ord.md
Name: pifo_set_ord

Overview:
Parametrised successor PIFO set with configurable depth, priority, data and flow-id widths.
- Selectable ordering mode: max-first or min-first.
- Stable FIFO tie-break: equal priorities dequeue in arrival order.
- Explicit reinsert handshake and per-flow occupancy counters, so a flow may hold several entries.
- Sits between flow-state logic and the scheduler output: up to one push, one pop and one reinsert per cycle.

Parameters:
NUM_ELEMENTS, 16, storage depth (>=2)
PRIO_WIDTH, 8, priority width
DATA_WIDTH, 8, flow-id width
NUM_FLOWS, 2**DATA_WIDTH, number of tracked flows
MIN_FIRST, 0, 0 = largest priority at head; 1 = smallest at head

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
i__push_valid  in  1  push request
i__push_priority  in  PRIO_WIDTH  push priority
i__push_flow_id  in  DATA_WIDTH  push flow id
o__push_ready  out  1  push accepted this cycle if valid
o__push_flow_empty  out  1  flow i__push_flow_id has zero entries in set
i__pop  in  1  dequeue head
o__pop_valid  out  1  head valid
o__pop_priority  out  PRIO_WIDTH  head priority
o__pop_flow_id  out  DATA_WIDTH  head flow id
i__reinsert_valid  in  1  re-enqueue popped head's flow
i__reinsert_priority  in  PRIO_WIDTH  new priority for reinsert
o__reinsert_err  out  1  reinsert without accepted pop (1-cycle pulse, registered)
o__count  out  $clog2(NUM_ELEMENTS+1)  occupancy
i__clear_all  in  1  synchronous flush

Behaviour:
- Interface is one clock, clk; reset is synchronous and active-high.
- Reset or i__clear_all: count=0, all entries invalid, flow counters=0, o__reinsert_err=0. Under reset, o__push_ready=0 and o__pop_valid=0. Clear overrides any same-cycle push/pop/reinsert; reset overrides clear.
- Accept conditions: push = i__push_valid & o__push_ready; pop = i__pop & o__pop_valid; reinsert = i__reinsert_valid & pop. An unaccepted reinsert sets o__reinsert_err next cycle and is dropped.
- o__push_ready = (count < NUM_ELEMENTS) & ~reset. Combinational from registered count; does not depend on same-cycle pop.
- count_next = count + push - pop + reinsert. Reinsert implies pop, so the increment is at most +1, and the full state never overflows.
- Head outputs are driven directly from entry[0] registers, with no combinational path from inputs. o__pop_valid = (count != 0).
- Latency: an accepted push or reinsert is visible at the head one cycle later if it ranks first. An accepted pop updates the head next cycle.
- Ordering: entry[i] precedes entry[i+1]. Precedes means strictly greater priority (MIN_FIRST=0) or strictly smaller (MIN_FIRST=1), or equal priority with earlier insertion.
- Insertion position for a new entry is after every remaining entry that does not strictly lose to it. Remaining entries are those with the head excluded when popping.
- Same-cycle push and reinsert with equal priority: the reinsert entry is placed ahead of the push entry.
- Next-state construction per slot: optional left shift by one (pop), then right shift past each insertion point. Two inserts may land in adjacent slots.
- Flow counters, width $clog2(NUM_ELEMENTS+1):
  - +1 on the push flow for push.
  - +1 on the head flow for reinsert.
  - -1 on the head flow for pop.
  - Net change per flow per cycle is applied in one update.
- o__push_flow_empty = (flow counter[i__push_flow_id] == 0), from registered state.
- Priority 0 is a legal value; reinsert is gated only by i__reinsert_valid.
- Invalid slots hold their previous contents and are never compared; the compare is masked by index < count.

Optional Feature:
Macro PIFO_SET_ORD_STATS_EN.
- Defined: adds outputs o__stat_push_cnt, o__stat_pop_cnt and o__stat_drop_cnt, each 32 bits.
  - o__stat_push_cnt counts accepted pushes; o__stat_pop_cnt counts accepted pops.
  - o__stat_drop_cnt counts cycles with i__push_valid & ~o__push_ready while not in reset.
  - All three wrap at 2^32 and are zeroed by reset and by i__clear_all.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package pifo_pkg holds:
  - localparams ORD_MAX_FIRST=0 and ORD_MIN_FIRST=1;
  - function prio_beats(a, b, min_first), which returns 1 when a strictly precedes b.
  - Entry struct typedefs stay module-local because they depend on widths.
- Sub-module pifo_insert_pos: given a compare vector of NUM_ELEMENTS bits and the valid mask, outputs the insertion index. It is instantiated twice, for push and reinsert.

Test Plan:
- Max-first ordering: push priorities 5, 9, 1, 9(flow 7) on consecutive cycles, then pop four times. Head order must be 9(first), 9(flow 7), 5, 1, and o__count must go 0,1,2,3,4,3,2,1,0.
- Min-first ordering: with MIN_FIRST=1, push priorities 30, 10, 20, then pop three times. Pops must return 10, 20, 30.
- Full boundary: fill 16 entries so o__push_ready=0. Then in one cycle assert push(prio 50), pop, and reinsert(prio 50) while the head has prio 50. The push must be refused, count must stay 16, and the reinsert entry must be placed after the existing prio-50 entries.
- Simultaneous push, pop and reinsert at count=3 (priorities 40, 20, 10): pop 40, reinsert 15, push 25. The resulting order must be 25, 20, 15, 10, count 4, and the popped flow's counter unchanged.
- Reinsert without pop: i__reinsert_valid=1 with i__pop=0. o__reinsert_err must be 1 next cycle, and count and the entries must be unchanged.
- Clear and reset mid-operation: assert i__clear_all together with push at count=5. Next cycle count=0 and o__pop_valid=0, and o__push_flow_empty=1 for all flows. A reset pulse gives the same result and forces o__push_ready=0 during reset.
